// File: rtl/nco_lut_driver_pkg.sv
// Shared audio constants and state type for the waveform LUT and its sample-rate drivers.
package nco_lut_driver_pkg;

  localparam int ADDR_W          = 10;
  localparam int DATA_W          = 16;
  localparam int DEFAULT_CLK_DIV = 1042;

  localparam logic [7:0] OVR_MAX = 8'hFF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    CAPTURE = 2'd2
  } state_t;

endpackage

// File: rtl/nco_lut_driver_if.sv
// LUT read port plus the outgoing sample stream; master is the driver, slave is LUT + consumer.
interface nco_lut_driver_if;
  import nco_lut_driver_pkg::*;

  logic [ADDR_W-1:0] lut_addr;
  logic [DATA_W-1:0] lut_data;
  logic [DATA_W-1:0] sample_data;
  logic              sample_valid;
  logic              sample_ready;

  modport master (
    output lut_addr,
    output sample_data,
    output sample_valid,
    input  lut_data,
    input  sample_ready
  );

  modport slave (
    input  lut_addr,
    input  sample_data,
    input  sample_valid,
    output lut_data,
    output sample_ready
  );

endinterface

// File: rtl/sample_tick_gen.sv
// Output-sample tick: one-cycle pulse every CLK_DIV enabled cycles, combinational from the divider.
// Divider is held at zero while enable is low, so the first tick lands CLK_DIV cycles after enable.
module sample_tick_gen #(
  parameter int CLK_DIV = 1042
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  if (CLK_DIV < 4) begin : g_bad_div
    $error("sample_tick_gen: CLK_DIV must be at least 4");
  end

  logic [CNT_W-1:0] div_cnt;

  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      div_cnt <= '0;
    end else if (div_cnt == CNT_LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + CNT_W'(1);
    end
  end

  assign tick = enable && (div_cnt == CNT_LAST);

endmodule

// File: rtl/nco_lut_driver.sv
// Phase-accumulator LUT address driver and sample collector; tick to sample_valid is 3 cycles.
// A captured sample is held until accepted; samples arriving while it is held are dropped and counted.
module nco_lut_driver
  import nco_lut_driver_pkg::*;
#(
  parameter int CLK_DIV = DEFAULT_CLK_DIV,
  parameter int PHASE_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [PHASE_W-1:0] tune_word,
  input  logic               phase_clr,
  nco_lut_driver_if.master   bus,
  output logic [7:0]         overrun_cnt
);

  state_t             state_q, state_d;
  logic [PHASE_W-1:0] phase_q, phase_d, phase_base;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               vld_q, vld_d;
  logic [7:0]         ovr_q, ovr_d;
  logic               tick;
  logic               slot_free;

  sample_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .tick   (tick)
  );

  assign slot_free = !vld_q || bus.sample_ready;

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    addr_d     = addr_q;
    data_d     = data_q;
    vld_d      = vld_q;
    ovr_d      = ovr_q;
    phase_base = phase_clr ? '0 : phase_q;

    if (vld_q && bus.sample_ready) begin
      vld_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (tick) begin
          addr_d  = phase_base[PHASE_W-1 -: ADDR_W];
          phase_d = phase_base + tune_word;
          state_d = FETCH;
        end
      end
      // LUT registers its output on the edge leaving FETCH.
      FETCH: begin
        state_d = CAPTURE;
      end
      CAPTURE: begin
        state_d = IDLE;
        if (slot_free) begin
          data_d = bus.lut_data;
          vld_d  = 1'b1;
        end else if (ovr_q != OVR_MAX) begin
          ovr_d = ovr_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      phase_q <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      vld_q   <= 1'b0;
      ovr_q   <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      vld_q   <= vld_d;
      ovr_q   <= ovr_d;
    end
  end

  assign bus.lut_addr     = addr_q;
  assign bus.sample_data  = data_q;
  assign bus.sample_valid = vld_q;
  assign overrun_cnt      = ovr_q;

endmodule

// File: tb/tb_nco_lut_driver.sv
// Bench for nco_lut_driver at CLK_DIV=8 with an identity LUT and an event-scheduled reference model.
module tb_nco_lut_driver;

  localparam int DIV = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [31:0] tune_word = '0;
  logic        phase_clr = 1'b0;
  logic [7:0]  overrun_cnt;

  int vectors = 0;
  int miscompares = 0;
  bit chk_on = 1'b0;

  nco_lut_driver_if bus_if ();

  nco_lut_driver #(
    .CLK_DIV (DIV),
    .PHASE_W (32)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .tune_word   (tune_word),
    .phase_clr   (phase_clr),
    .bus         (bus_if.master),
    .overrun_cnt (overrun_cnt)
  );

  always #5 clk = ~clk;

  // Identity LUT with a one-cycle registered read.
  always @(posedge clk) bus_if.lut_data <= {6'd0, bus_if.lut_addr};

  // Reference model: a tick is the DIV-th consecutive enabled cycle; its sample lands two edges later.
  logic [31:0] m_phase = '0;
  logic [9:0]  m_addr = '0;
  logic [15:0] m_data = '0;
  logic        m_vld = 1'b0;
  int          m_ovr = 0;
  int          m_run = 0;
  int          cyc = 0;
  int          cap_due = -1;
  logic [15:0] cap_val = '0;

  always @(posedge clk) begin : model
    logic [31:0] base;
    logic        nv;
    if (reset) begin
      m_phase = '0; m_addr = '0; m_data = '0; m_vld = 1'b0;
      m_ovr = 0; m_run = 0; cap_due = -1;
    end else begin
      nv = m_vld && !bus_if.sample_ready;
      if (cyc == cap_due) begin
        if (!m_vld || bus_if.sample_ready) begin
          m_data = cap_val;
          nv = 1'b1;
        end else if (m_ovr < 255) begin
          m_ovr = m_ovr + 1;
        end
        cap_due = -1;
      end
      m_vld = nv;
      m_run = enable ? m_run + 1 : 0;
      if (enable && (m_run % DIV) == 0) begin
        base    = phase_clr ? 32'd0 : m_phase;
        m_addr  = base[31:22];
        m_phase = base + tune_word;
        cap_val = {6'd0, m_addr};
        cap_due = cyc + 2;
      end
    end
    cyc = cyc + 1;
  end

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors = vectors + 1;
    if (act !== exp) begin
      miscompares = miscompares + 1;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  always @(negedge clk) begin
    if (chk_on) begin
      chk("model_lut_addr", 32'(bus_if.lut_addr), 32'(m_addr));
      chk("model_sample_valid", 32'(bus_if.sample_valid), 32'(m_vld));
      if (m_vld) chk("model_sample_data", 32'(bus_if.sample_data), 32'(m_data));
      chk("model_overrun_cnt", 32'(overrun_cnt), 32'(m_ovr));
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Advance so the next cycle is a tick (enable must be high).
  task automatic to_tick();
    while (((m_run + 1) % DIV) != 0) step();
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!bus_if.sample_valid && n < 40) begin
      step();
      n++;
    end
    if (!bus_if.sample_valid) chk("wait_valid_timeout", 32'(bus_if.sample_valid), 32'd1);
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    enable = 1'b0;
    repeat (2) step();
    reset = 1'b0;
  endtask

  typedef struct {
    logic        en;
    logic        rdy;
    logic [9:0]  addr;
    logic        vld;
    logic [15:0] data;
  } vec_t;

  vec_t tbl[18];

  initial begin
    int n;
    // Cycle i of the run after reset; expectations are outputs visible in cycle i+1.
    for (int i = 0; i < 18; i++) begin
      tbl[i].en   = 1'b1;
      tbl[i].rdy  = 1'b1;
      tbl[i].addr = (i + 1 >= 16) ? 10'd1 : 10'd0;
      tbl[i].vld  = (i + 1 == 10) || (i + 1 == 18);
      tbl[i].data = (i + 1 >= 18) ? 16'd1 : 16'd0;
    end

    bus_if.sample_ready = 1'b0;
    @(negedge clk);
    do_reset();
    chk_on = 1'b1;
    chk("reset_lut_addr", 32'(bus_if.lut_addr), 32'd0);
    chk("reset_sample_data", 32'(bus_if.sample_data), 32'd0);
    chk("reset_sample_valid", 32'(bus_if.sample_valid), 32'd0);
    chk("reset_overrun_cnt", 32'(overrun_cnt), 32'd0);

    // Latency: tick in cycle 8, address in 9, valid in 11 and not before.
    tune_word = 32'h0040_0000;
    for (int i = 0; i < 18; i++) begin
      enable = tbl[i].en;
      bus_if.sample_ready = tbl[i].rdy;
      step();
      chk($sformatf("tbl%0d_lut_addr", i), 32'(bus_if.lut_addr), 32'(tbl[i].addr));
      chk($sformatf("tbl%0d_valid", i), 32'(bus_if.sample_valid), 32'(tbl[i].vld));
      chk($sformatf("tbl%0d_data", i), 32'(bus_if.sample_data), 32'(tbl[i].data));
    end

    // One LUT step per sample through the 1023 -> 0 wrap.
    step();
    for (int k = 2; k < 1030; k++) begin
      wait_valid(n);
      chk("step_sample_data", 32'(bus_if.sample_data), 32'(k % 1024));
      step();
    end

    // Backpressure: first sample held, next two dropped.
    do_reset();
    enable = 1'b1;
    bus_if.sample_ready = 1'b0;
    tune_word = 32'h0040_0000;
    repeat (3 * DIV + 3) step();
    chk("bp_valid_held", 32'(bus_if.sample_valid), 32'd1);
    chk("bp_data_held", 32'(bus_if.sample_data), 32'd0);
    chk("bp_overrun_2", 32'(overrun_cnt), 32'd2);

    // Accept on the same edge as a capture.
    to_tick();
    step();
    step();
    bus_if.sample_ready = 1'b1;
    step();
    bus_if.sample_ready = 1'b0;
    chk("same_edge_valid", 32'(bus_if.sample_valid), 32'd1);
    chk("same_edge_data", 32'(bus_if.sample_data), 32'd3);
    chk("same_edge_overrun", 32'(overrun_cnt), 32'd2);

    repeat (300 * DIV) step();
    chk("overrun_saturated", 32'(overrun_cnt), 32'd255);
    bus_if.sample_ready = 1'b1;
    step();

    // phase_clr at a tick, with phase parked near mid-scale.
    to_tick();
    tune_word = 32'h8000_0000;
    phase_clr = 1'b1;
    step();
    phase_clr = 1'b0;
    tune_word = 32'h0;
    chk("clr_first_addr", 32'(bus_if.lut_addr), 32'd0);
    to_tick();
    step();
    chk("mid_scale_addr", 32'(bus_if.lut_addr), 32'h200);
    to_tick();
    phase_clr = 1'b1;
    step();
    phase_clr = 1'b0;
    chk("clr_mid_addr", 32'(bus_if.lut_addr), 32'd0);

    // Reset during FETCH discards the in-flight sample.
    tune_word = 32'h1234_5678;
    to_tick();
    step();
    to_tick();
    step();
    chk("pre_reset_addr", 32'(bus_if.lut_addr), 32'h048);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("fetch_reset_addr", 32'(bus_if.lut_addr), 32'd0);
    chk("fetch_reset_valid", 32'(bus_if.sample_valid), 32'd0);
    chk("fetch_reset_data", 32'(bus_if.sample_data), 32'd0);
    chk("fetch_reset_overrun", 32'(overrun_cnt), 32'd0);
    repeat (6) begin
      step();
      chk("no_sample_after_reset", 32'(bus_if.sample_valid), 32'd0);
    end

    // Constant address: one sample of value 0 every DIV cycles.
    tune_word = 32'h0;
    wait_valid(n);
    step();
    for (int p = 0; p < 3; p++) begin
      wait_valid(n);
      chk("const_period", 32'(n + 1), 32'(DIV));
      chk("const_data", 32'(bus_if.sample_data), 32'd0);
      chk("const_addr", 32'(bus_if.lut_addr), 32'd0);
      step();
    end

    // Random traffic against the model, including off-tick tune_word/phase_clr changes.
    for (int r = 0; r < 4000; r++) begin
      enable              = ($urandom_range(0, 19) != 0);
      bus_if.sample_ready = ($urandom_range(0, 2) != 0);
      tune_word           = $urandom;
      phase_clr           = ($urandom_range(0, 9) == 0);
      reset               = ($urandom_range(0, 599) == 0);
      step();
    end
    reset = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/nco_lut_driver.md
# nco_lut_driver

Sample-rate phase driver and sample collector for the audio waveform LUT. It generates the 10-bit LUT read address from a 32-bit phase accumulator once per output-sample tick, waits out the LUT's one-cycle registered read, and captures the returned 16-bit sample. It presents the sample on a valid/ready stream to the equalizer / FIR/IIR datapath. It sits between the tuning-word control register and the filter input.

## Interface

**Parameters**
- CLK_DIV, 1042: system clocks per output sample (50 MHz / 48 kHz); legal range ≥ 4.
- PHASE_W, 32: phase accumulator width.
- ADDR_W, 10: LUT address width; address = phase[PHASE_W-1 -: ADDR_W].
- DATA_W, 16: sample width.

**Ports**
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  run tone generation; low holds the divider at 0.
- tune_word  in  PHASE_W  phase increment per sample; sampled only in the tick cycle.
- phase_clr  in  1  level; if high in a tick cycle, that tick's address is 0 and phase restarts at tune_word.
- lut_addr  out  ADDR_W  registered address to the LUT phase input.
- lut_data  in  DATA_W  LUT registered output; valid one cycle after lut_addr changes.
- sample_data  out  DATA_W  captured sample.
- sample_valid  out  1  sample_data holds an unaccepted sample.
- sample_ready  in  1  consumer accepts when sample_valid && sample_ready.
- overrun_cnt  out  8  saturating count of samples dropped due to backpressure.

## Operation

- **Reset:** lut_addr=0, sample_data=0, sample_valid=0, overrun_cnt=0, phase=0, divider=0, state=IDLE.
- **Divider:** div_cnt counts 0..CLK_DIV-1 while enable=1 and wraps to 0. tick = enable && div_cnt==CLK_DIV-1. When enable=0, div_cnt is cleared each cycle.
- **FSM states:** IDLE, FETCH, CAPTURE.
  - IDLE + tick → FETCH. Same edge: lut_addr ← phase_next MSBs; phase ← phase_next + tune_word. phase_next = phase_clr ? 0 : phase.
  - FETCH → CAPTURE unconditionally; the LUT registers lut_data on this edge.
  - CAPTURE → IDLE unconditionally. If the slot is free (!sample_valid || sample_ready), then sample_data ← lut_data and sample_valid ← 1. Otherwise the sample is dropped and overrun_cnt increments, saturating at 255.
- **Phase arithmetic:** modulo 2^PHASE_W, with no saturation. The address wraps 1023→0 naturally.
- **Handshake:** sample_valid, once high, stays high with sample_data stable until a cycle with sample_ready=1. In a non-CAPTURE cycle with valid && ready, sample_valid ← 0.
- **Simultaneous accept and capture:** if valid && ready occur in a CAPTURE cycle, the new sample loads, sample_valid stays 1, and overrun_cnt is unchanged.
- **enable deasserted mid-fetch:** the in-flight sample completes (FETCH/CAPTURE proceed) and no further ticks occur. A pending output sample is held regardless of enable.
- **tune_word or phase_clr outside the tick cycle:** ignored.
- **reset mid-operation:** the FSM aborts to IDLE, the in-flight sample is discarded, and all outputs return to reset values on the next edge.

## Timing

- With the tick in cycle T:
  - lut_addr updates at the edge ending T (visible in T+1).
  - lut_data is valid in T+2.
  - sample_valid first rises in T+3.
- Tick-to-sample latency: 3 cycles.
- Output rate: exactly one sample per CLK_DIV cycles. CLK_DIV ≥ 4 guarantees the FSM is in IDLE before the next tick.
- Accept-to-deassert: sample_valid falls the cycle after the handshake, unless a CAPTURE occurs on the same edge.
- overrun_cnt updates at the CAPTURE edge.

## Structure

- Shared audio package holds:
  - ADDR_W = 10 and DATA_W = 16, shared with the LUT.
  - The default CLK_DIV (1042).
  - The state typedef {IDLE, FETCH, CAPTURE}.
- One natural sub-module: sample_tick_gen (parameter CLK_DIV; ports clk, reset, enable, tick), reused by other sample-rate blocks.
- The phase accumulator, FSM and output register stay in nco_lut_driver.

## Test plan

All scenarios use CLK_DIV=8 with a behavioural LUT model (1-cycle registered read, LUT[i]=i).

1. **Constant address:** tune_word=0, enable=1, ready=1 → a sample every 8 cycles, lut_addr=0 and sample_data=0x0000 throughout.
2. **Address stepping and wrap:** tune_word=0x0040_0000 (one LUT step) → lut_addr sequence 0,1,2,…,1023,0. sample_data follows one sample period behind, and phase wraps without a glitch.
3. **Latency:** first tick in cycle T → lut_addr=0 in T+1, sample_valid=1 with sample_data=0 in T+3, and no earlier valid.
4. **Backpressure:** ready=0 for 3 sample periods → first sample held stable, next two dropped, overrun_cnt=2. After forcing 300 drops → overrun_cnt=255.
5. **Same-edge accept and capture:** ready pulsed exactly in a CAPTURE cycle → valid stays 1, new data loads, overrun_cnt unchanged.
6. **phase_clr and reset:**
   - phase_clr=1 at a tick while phase≈0x8000_0000 → that tick's lut_addr=0.
   - reset asserted in a FETCH cycle → all outputs 0 next cycle and no sample emitted for that tick.
